// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the I/D-cache memory arbiter.
// Grant policy is selected by MEM_ARB_ROUND_ROBIN_EN in mem_arbiter.sv.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } last_grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and shared memory ports of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        output i_mem_rdata, i_mem_ready,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        input  i_mem_rdata, i_mem_ready,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache, D-cache) arbiter onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on ties; default is D-cache priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input logic          clk,
    input logic          proc_reset,
    mem_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        grant;
    logic              i_req;
    logic              d_req;
    logic              read_mux;
    logic              write_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_t       last;
`endif

    assign i_req = bus.i_mem_read | bus.i_mem_write;
    assign d_req = bus.d_mem_read | bus.d_mem_write;

    always_comb begin
        grant = IDLE;
        if (d_req) begin
            grant = GNT_D;
        end else if (i_req) begin
            grant = GNT_I;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie, favour whichever requester was not served last.
        if (i_req && d_req) begin
            grant = (last == LAST_D) ? GNT_I : GNT_D;
        end
`endif
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last  <= LAST_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (grant == GNT_I) begin
                        last <= LAST_I;
                    end else if (grant == GNT_D) begin
                        last <= LAST_D;
                    end
`endif
                end
                GNT_I, GNT_D: begin
                    if (bus.mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port mux is combinational off the registered grant so a granted request
    // reaches memory in the first grant cycle.
    always_comb begin
        read_mux  = 1'b0;
        write_mux = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        case (state)
            GNT_I: begin
                read_mux  = bus.i_mem_read;
                write_mux = bus.i_mem_write;
                addr_mux  = bus.i_mem_addr;
                wdata_mux = bus.i_mem_wdata;
            end
            GNT_D: begin
                read_mux  = bus.d_mem_read;
                write_mux = bus.d_mem_write;
                addr_mux  = bus.d_mem_addr;
                wdata_mux = bus.d_mem_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_read    = read_mux;
    assign bus.mem_write   = write_mux;
    assign bus.mem_addr    = addr_mux;
    assign bus.mem_wdata   = wdata_mux;

    assign bus.i_mem_ready = bus.mem_ready & (state == GNT_I);
    assign bus.d_mem_ready = bus.mem_ready & (state == GNT_D);
    assign bus.i_mem_rdata = bus.mem_rdata;
    assign bus.d_mem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: per-requester transaction queues, a memory
// responder with random latency, and an owner-level reference model.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic proc_reset = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .bus       (bus)
    );

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    // Outstanding transactions per requester; head is what the requester drives.
    op_t iq[$];
    op_t dq[$];
    // Owner of the memory port: 0 none, 1 I-cache, 2 D-cache.
    int  owner    = 0;
    int  last     = 1;
    int  lat_left = 0;
    int  lat_cfg  = -1;
    bit  spur_en  = 1'b0;
    bit  spur_force = 1'b0;
    int  grants[$];
    int  rd_hi    = 0;
    int  n_cmp    = 0;
    int  n_bad    = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic rd, input logic wr,
                                  input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        op_t o;
        o.rd = rd;
        o.wr = wr;
        o.addr = addr;
        o.wdata = wdata;
        return o;
    endfunction

    function automatic op_t rand_op();
        int kind;
        kind = $urandom_range(1, 3);
        return mk_op(kind[0], kind[1], AW'($urandom),
                     {$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic drive_req();
        if (iq.size() > 0) begin
            bus.i_mem_read  = iq[0].rd;
            bus.i_mem_write = iq[0].wr;
            bus.i_mem_addr  = iq[0].addr;
            bus.i_mem_wdata = iq[0].wdata;
        end else begin
            bus.i_mem_read  = 1'b0;
            bus.i_mem_write = 1'b0;
            bus.i_mem_addr  = AW'($urandom);
            bus.i_mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (dq.size() > 0) begin
            bus.d_mem_read  = dq[0].rd;
            bus.d_mem_write = dq[0].wr;
            bus.d_mem_addr  = dq[0].addr;
            bus.d_mem_wdata = dq[0].wdata;
        end else begin
            bus.d_mem_read  = 1'b0;
            bus.d_mem_write = 1'b0;
            bus.d_mem_addr  = AW'($urandom);
            bus.d_mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+4, advance the model.
    task automatic step(input bit rst);
        op_t           cur;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        int            pick;
        proc_reset = rst;
        if (rst) begin
            owner = 0;
            last  = 1;
        end
        drive_req();
        if (owner != 0) begin
            bus.mem_ready = (lat_left == 0);
            if (lat_left > 0) lat_left--;
        end else begin
            bus.mem_ready = spur_force || (spur_en && $urandom_range(0, 7) == 0);
        end
        bus.mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        #3;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
        if (owner != 0) begin
            if (owner == 1) cur = iq[0];
            else            cur = dq[0];
            e_rd = cur.rd; e_wr = cur.wr; e_addr = cur.addr; e_wdata = cur.wdata;
        end
        check("mem_read",    DW'(bus.mem_read),  DW'(e_rd));
        check("mem_write",   DW'(bus.mem_write), DW'(e_wr));
        check("mem_addr",    DW'(bus.mem_addr),  DW'(e_addr));
        check("mem_wdata",   bus.mem_wdata,      e_wdata);
        check("i_mem_ready", DW'(bus.i_mem_ready), DW'(owner == 1 && bus.mem_ready));
        check("d_mem_ready", DW'(bus.d_mem_ready), DW'(owner == 2 && bus.mem_ready));
        check("i_mem_rdata", bus.i_mem_rdata, bus.mem_rdata);
        check("d_mem_rdata", bus.d_mem_rdata, bus.mem_rdata);
        if (bus.i_mem_ready) grants.push_back(1);
        if (bus.d_mem_ready) grants.push_back(2);
        if (bus.mem_read) rd_hi++;
        if (!rst) begin
            if (owner != 0) begin
                if (bus.mem_ready) begin
                    if (owner == 1) void'(iq.pop_front());
                    else            void'(dq.pop_front());
                    owner = 0;
                end
            end else if (iq.size() > 0 || dq.size() > 0) begin
                if (iq.size() > 0 && dq.size() > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    pick = (last == 1) ? 2 : 1;
`else
                    pick = 2;
`endif
                end else begin
                    pick = (iq.size() > 0) ? 1 : 2;
                end
                owner    = pick;
                last     = pick;
                lat_left = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        iq.delete();
        dq.delete();
        step(1'b1);
        step(1'b1);
        grants.delete();
        rd_hi = 0;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (grants.size() < n && c < budget) begin
            step(1'b0);
            c++;
        end
        check(tag, DW'(grants.size()), DW'(n));
    endtask

    function automatic int grant_at(input int idx);
        return (idx < grants.size()) ? grants[idx] : 0;
    endfunction

    initial begin
        int exp3[4];
        int exp4[3];
        bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; bus.i_mem_addr = '0; bus.i_mem_wdata = '0;
        bus.d_mem_read = 1'b0; bus.d_mem_write = 1'b0; bus.d_mem_addr = '0; bus.d_mem_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        @(posedge clk);
        #1;
        do_reset();

        // D-cache read alone, memory answers 3 cycles after the request appears.
        lat_cfg = 3;
        dq.push_back(mk_op(1'b1, 1'b0, 28'h0000010, '0));
        run_until(1, 20, "s1_count");
        step(1'b0);
        step(1'b0);
        check("s1_owner", DW'(grant_at(0)), DW'(2));
        check("s1_ready_pulses", DW'(grants.size()), DW'(1));
        check("s1_rd_cycles", DW'(rd_hi), DW'(4));

        // Simultaneous requests from reset.
        do_reset();
        lat_cfg = -1;
        iq.push_back(mk_op(1'b1, 1'b0, AW'($urandom), '0));
        dq.push_back(mk_op(1'b1, 1'b0, AW'($urandom), '0));
        run_until(2, 30, "s2_count");
        check("s2_first", DW'(grant_at(0)), DW'(2));
        check("s2_second", DW'(grant_at(1)), DW'(1));

        // Both request continuously for four transactions.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            iq.push_back(rand_op());
            dq.push_back(rand_op());
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp3 = '{2, 1, 2, 1};
`else
        exp3 = '{2, 2, 2, 2};
`endif
        run_until(4, 60, "s3_count");
        for (int i = 0; i < 4; i++) check($sformatf("s3_grant%0d", i), DW'(grant_at(i)), DW'(exp3[i]));

        // D write-back then refill while the I-cache is pending.
        do_reset();
        dq.push_back(mk_op(1'b0, 1'b1, AW'($urandom), {16{8'hA5}}));
        dq.push_back(mk_op(1'b1, 1'b0, AW'($urandom), '0));
        iq.push_back(mk_op(1'b1, 1'b0, AW'($urandom), '0));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp4 = '{2, 1, 2};
`else
        exp4 = '{2, 2, 1};
`endif
        run_until(3, 60, "s4_count");
        for (int i = 0; i < 3; i++) check($sformatf("s4_grant%0d", i), DW'(grant_at(i)), DW'(exp4[i]));

        // Reset landing in the middle of an I-cache grant.
        do_reset();
        lat_cfg = 6;
        iq.push_back(mk_op(1'b1, 1'b0, AW'($urandom), '0));
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        lat_cfg = 1;
        run_until(1, 20, "s5_count");
        check("s5_owner", DW'(grant_at(0)), DW'(1));

        // Stray mem_ready while idle.
        do_reset();
        lat_cfg = -1;
        spur_force = 1'b1;
        step(1'b0);
        spur_force = 1'b0;
        step(1'b0);
        step(1'b0);
        check("s6_no_ready", DW'(grants.size()), DW'(0));

        // Random traffic with stray readies and occasional resets.
        do_reset();
        spur_en = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (iq.size() == 0 && $urandom_range(0, 2) == 0) iq.push_back(rand_op());
            if (dq.size() == 0 && $urandom_range(0, 2) == 0) dq.push_back(rand_op());
            step($urandom_range(0, 199) == 0);
        end
        check("rand_progress", DW'(grants.size() > 100), DW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
